// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN timestep controller and its address decoder.
package snn_pkg;

    localparam int unsigned NUM_CORES = 2;

    // enable_calc bit encoding, identical to the address decoder's view
    localparam logic [NUM_CORES-1:0] EN_CALC_NONE  = 2'b00;
    localparam logic [NUM_CORES-1:0] EN_CALC_CORE0 = 2'b01;
    localparam logic [NUM_CORES-1:0] EN_CALC_CORE1 = 2'b10;
    localparam logic [NUM_CORES-1:0] EN_CALC_ALL   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CALC   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    function automatic logic mask_covered(input logic [NUM_CORES-1:0] seen,
                                          input logic [NUM_CORES-1:0] mask);
        return (seen & mask) == mask;
    endfunction

endpackage

// File: rtl/snn_step_ctrl_if.sv
// Host/core handshake bundle of the SNN timestep controller; the host side is master.
interface snn_step_ctrl_if #(
    parameter int unsigned STEP_W = 16
);
    import snn_pkg::*;

    logic                 start_i;
    logic                 abort_i;
    logic [STEP_W-1:0]    num_steps_i;
    logic [NUM_CORES-1:0] core_mask_i;
    logic                 spike_in_valid_i;
    logic [NUM_CORES-1:0] core_done_i;
    logic                 spike_out_ack_i;

    logic [NUM_CORES-1:0] enable_calc_o;
    logic                 spike_in_req_o;
    logic                 spike_out_valid_o;
    logic [STEP_W-1:0]    step_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 timeout_o;

    modport master (
        output start_i, abort_i, num_steps_i, core_mask_i,
               spike_in_valid_i, core_done_i, spike_out_ack_i,
        input  enable_calc_o, spike_in_req_o, spike_out_valid_o,
               step_o, busy_o, done_o, timeout_o
    );

    modport slave (
        input  start_i, abort_i, num_steps_i, core_mask_i,
               spike_in_valid_i, core_done_i, spike_out_ack_i,
        output enable_calc_o, spike_in_req_o, spike_out_valid_o,
               step_o, busy_o, done_o, timeout_o
    );

endinterface

// File: rtl/snn_calc_wdt.sv
// CALC-phase watchdog: counts consecutive CALC cycles and flags the TIMEOUT-th one.
module snn_calc_wdt #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic calc_active_i,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // restarts from zero on every CALC entry, so each step gets a fresh budget
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (calc_active_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign expire_c = calc_active_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/snn_step_ctrl.sv
// Timestep sequencer for a two-core SNN accelerator: LOAD -> CALC -> DRAIN per step.
// Optional CALC watchdog built in when SNN_CTRL_TIMEOUT_EN is defined.
module snn_step_ctrl
    import snn_pkg::*;
#(
    parameter int unsigned STEP_W  = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    snn_step_ctrl_if.slave  bus
);

    state_e               state_q, state_d;
    logic [STEP_W-1:0]    steps_q, steps_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [NUM_CORES-1:0] seen_q, seen_d;
    logic [NUM_CORES-1:0] en_q, en_d;
    logic                 in_req_q, in_req_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 wdt_expire_c;
    logic [NUM_CORES-1:0] hit_c;

`ifdef SNN_CTRL_TIMEOUT_EN
    snn_calc_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .calc_active_i (state_q == ST_CALC),
        .expire_c      (wdt_expire_c)
    );
`else
    // TIMEOUT only matters once the watchdog is built in
    assign wdt_expire_c = 1'b0 && (TIMEOUT != 0);
`endif

    assign hit_c = bus.core_done_i & mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state plus next value of every registered output
    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        step_d      = step_q;
        mask_d      = mask_q;
        seen_d      = seen_q;
        timeout_d   = timeout_q;
        en_d        = EN_CALC_NONE;
        done_d      = 1'b0;
        in_req_d    = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        if (bus.abort_i) begin
            state_d = ST_IDLE;
            seen_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        if ((bus.num_steps_i != '0) && (bus.core_mask_i != '0)) begin
                            state_d   = ST_LOAD;
                            steps_d   = bus.num_steps_i;
                            mask_d    = bus.core_mask_i;
                            step_d    = '0;
                            seen_d    = '0;
                            timeout_d = 1'b0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.spike_in_valid_i) begin
                        state_d = ST_CALC;
                        seen_d  = '0;
                        en_d    = mask_q;
                    end
                end
                ST_CALC: begin
                    seen_d = seen_q | hit_c;
                    if (mask_covered(seen_d, mask_q)) begin
                        state_d = ST_DRAIN;
                    end else if (wdt_expire_c) begin
                        state_d   = ST_FINISH;
                        timeout_d = 1'b1;
                    end else begin
                        en_d = mask_q & ~seen_d;
                    end
                end
                ST_DRAIN: begin
                    if (bus.spike_out_ack_i) begin
                        if (step_q == steps_q - STEP_W'(1)) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d = ST_LOAD;
                            step_d  = step_q + STEP_W'(1);
                            seen_d  = '0;
                        end
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // state-shaped outputs follow the state being entered
        in_req_d    = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_DRAIN);
        busy_d      = (state_d != ST_IDLE);
        done_d      = done_d || (state_d == ST_FINISH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            steps_q     <= '0;
            step_q      <= '0;
            mask_q      <= '0;
            seen_q      <= '0;
            en_q        <= EN_CALC_NONE;
            in_req_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            steps_q     <= steps_d;
            step_q      <= step_d;
            mask_q      <= mask_d;
            seen_q      <= seen_d;
            en_q        <= en_d;
            in_req_q    <= in_req_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.enable_calc_o     = en_q;
    assign bus.spike_in_req_o    = in_req_q;
    assign bus.spike_out_valid_o = out_valid_q;
    assign bus.step_o            = step_q;
    assign bus.busy_o            = busy_q;
    assign bus.done_o            = done_q;
    assign bus.timeout_o         = timeout_q;

endmodule

// File: doc/snn_step_ctrl.md
SNN_STEP_CTRL -- requirements
Module: snn_step_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 16, width of the timestep counter and num_steps_i.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum CALC cycles per step before abort (used only with SNN_CTRL_TIMEOUT_EN).
REQ-003 SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  run request, sampled only in IDLE.
REQ-007 abort_i  input  1  synchronous abort, any state.
REQ-008 num_steps_i  input  STEP_W  timesteps per run, latched on accepted start.
REQ-009 core_mask_i  input  2  participating cores (bit0 core 0, bit1 core 1), latched on accepted start.
REQ-010 spike_in_valid_i  input  1  host has written input spikes for the current step.
REQ-011 core_done_i  input  2  per-core calculation-done pulse.
REQ-012 spike_out_ack_i  input  1  host has read output spikes.
REQ-013 enable_calc_o  output  2  per-core calc enable, same bit encoding as the address decoder's enable_calc.
REQ-014 spike_in_req_o  output  1  request for input spikes.
REQ-015 spike_out_valid_o  output  1  output spikes ready for host.
REQ-016 step_o  output  STEP_W  current timestep index.
REQ-017 busy_o  output  1  high whenever state != IDLE.
REQ-018 done_o  output  1  one-cycle run-complete pulse.
REQ-019 timeout_o  output  1  sticky calc-timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, CALC, DRAIN, FINISH.
REQ-021 IDLE: start_i with num_steps_i != 0 and core_mask_i != 0 -> LOAD, latch num_steps/mask, step_o = 0, clear timeout_o.
REQ-022 IDLE: start_i with num_steps_i == 0 or core_mask_i == 0 -> done_o pulse next cycle, stay IDLE.
REQ-023 start_i outside IDLE SHALL be ignored.
REQ-024 LOAD: spike_in_req_o = 1; spike_in_valid_i -> CALC; enable_calc_o = latched mask from the first CALC cycle.
REQ-025 CALC: done_seen register SHALL accumulate core_done_i & mask; enable_calc_o = mask & ~done_seen, so a core's enable drops the cycle after its done.
REQ-026 CALC: when (done_seen | core_done_i) covers mask -> DRAIN; done on an unmasked core SHALL be ignored; both dones in the same cycle SHALL be accepted.
REQ-027 DRAIN: spike_out_valid_o = 1; on spike_out_ack_i, step_o == num_steps-1 -> FINISH, else step_o increments and -> LOAD with done_seen cleared.
REQ-028 FINISH: done_o = 1 for exactly one cycle, then IDLE; step_o holds final index until next accepted start.
REQ-029 abort_i SHALL take priority over all transitions: -> IDLE next cycle, enable_calc_o = 0, no done_o pulse.
REQ-030 step counter SHALL never wrap: num_steps_i = 2^STEP_W-1 runs exactly that many steps.
REQ-031 All outputs SHALL be registered; each handshake input is consumed at most once per state visit.

Reset
REQ-032 On rst_ni low: state IDLE, enable_calc_o = 0, spike_in_req_o = 0, spike_out_valid_o = 0, step_o = 0, busy_o = 0, done_o = 0, timeout_o = 0, done_seen = 0.
REQ-033 Reset mid-run SHALL discard the run with no done_o pulse.

Configuration
REQ-034 With SNN_CTRL_TIMEOUT_EN defined: CALC cycle counter; reaching TIMEOUT cycles without completion sets timeout_o, clears enable_calc_o, -> FINISH (done_o pulses).
REQ-035 Without SNN_CTRL_TIMEOUT_EN: no counter; timeout_o tied 0; port list unchanged.

Structure
REQ-036 Package snn_pkg SHALL hold the state enum, NUM_CORES = 2, and the enable_calc bit-encoding constants shared with the decoder.
REQ-037 The timeout counter SHALL be sub-module snn_calc_wdt, instantiated only under SNN_CTRL_TIMEOUT_EN.

Verification
REQ-038 num_steps=3, mask=2'b11, valid/done/ack each after 2 cycles -> three LOAD/CALC/DRAIN passes, step_o 0,1,2, one done_o pulse.
REQ-039 mask=2'b01, core_done_i=2'b10 then 2'b01 -> first ignored, DRAIN only after bit0, enable_calc_o never bit1.
REQ-040 core_done_i=2'b01 cycle 3, 2'b10 cycle 7 -> enable_calc_o 2'b11 -> 2'b10 -> 2'b00, DRAIN after cycle 7.
REQ-041 start with num_steps=0 -> done_o one cycle later, busy_o stays 0.
REQ-042 abort_i during CALC step 1 -> IDLE next cycle, enable_calc_o=0, no done_o; rst_ni low mid-DRAIN -> all outputs at reset values.
REQ-043 SNN_CTRL_TIMEOUT_EN, TIMEOUT=8, no core_done -> after 8 CALC cycles timeout_o=1, done_o pulse, timeout_o cleared by next accepted start.
